// File: rtl/vector_logical_pkg.sv
// Shared opcodes, FSM state type and operand-use decode for the vector logical sequencer.
package vector_logical_pkg;

  localparam logic [6:0] SCAL_AND = 7'b1100000;
  localparam logic [6:0] VEC_AND  = 7'b1100001;
  localparam logic [6:0] SCAL_OR  = 7'b1100010;
  localparam logic [6:0] VEC_OR   = 7'b1100011;
  localparam logic [6:0] SCAL_XOR = 7'b1100100;
  localparam logic [6:0] VEC_XOR  = 7'b1100101;
  localparam logic [6:0] SCAL_MRG = 7'b1100110;
  localparam logic [6:0] VEC_MRG  = 7'b1100111;
  localparam logic [6:0] VEC_MASK = 7'b1111101;

  localparam int NUM_VREGS = 8;
  localparam int ELEM_W    = 6;
  localparam int MAX_VL    = 64;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  typedef struct packed {
    logic uses_vi;
    logic uses_vj;
    logic uses_vk;
    logic writes_vm;
  } use_t;

  function automatic logic is_legal(input logic [6:0] instr);
    return (instr[6:3] == 4'b1100) || (instr == VEC_MASK);
  endfunction

  function automatic use_t decode_use(input logic [6:0] instr,
                                      input logic [2:0] i,
                                      input logic [2:0] j,
                                      input logic [2:0] k);
    use_t u;
    u = '0;
    if (instr == VEC_MASK) begin
      u.uses_vj   = 1'b1;
      u.writes_vm = 1'b1;
    end else if (instr == VEC_XOR && i == j && j == k) begin
      // Vi xor Vi is a clear: no operands actually read.
      u.uses_vi = 1'b1;
    end else if (is_legal(instr)) begin
      u.uses_vi = 1'b1;
      u.uses_vk = 1'b1;
      u.uses_vj = instr[0];
    end
    return u;
  endfunction

  function automatic logic [NUM_VREGS-1:0] use_mask(input use_t u,
                                                    input logic [2:0] i,
                                                    input logic [2:0] j,
                                                    input logic [2:0] k);
    logic [NUM_VREGS-1:0] m;
    m = '0;
    if (u.uses_vi) m[i] = 1'b1;
    if (u.uses_vj) m[j] = 1'b1;
    if (u.uses_vk) m[k] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/vl_write_delay.sv
// LATENCY-deep valid/index/last pipeline aligning element writes with the unit's result stream.
module vl_write_delay
  import vector_logical_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_elem,
  input  logic              in_last,
  output logic              out_valid,
  output logic [ELEM_W-1:0] out_elem,
  output logic              out_last
);

  logic [LATENCY-1:0]             valid_q;
  logic [LATENCY-1:0]             last_q;
  logic [LATENCY-1:0][ELEM_W-1:0] elem_q;

  // NOTE: the whole pipe is reset, not just valid, so an aborted instruction
  // can never leak a write or VM pulse after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
      elem_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      last_q[0]  <= in_last;
      elem_q[0]  <= in_elem;
      for (int s = 1; s < LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
        last_q[s]  <= last_q[s-1];
        elem_q[s]  <= elem_q[s-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_last  = last_q[LATENCY-1];
  assign out_elem  = elem_q[LATENCY-1];

endmodule

// File: rtl/vector_logical_sequencer.sv
// Issue-side sequencer for the vector logical unit: accept/reservation check,
// element read stepping, delayed Vi/VM writes and own register reservations.
module vector_logical_sequencer
  import vector_logical_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int VL_W    = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_issue,
  input  logic [6:0]           i_instr,
  input  logic [2:0]           i_i,
  input  logic [2:0]           i_j,
  input  logic [2:0]           i_k,
  input  logic [VL_W-1:0]      i_vl,
  input  logic [NUM_VREGS-1:0] i_vreg_busy_ext,
  output logic                 o_ready,
  output logic                 o_accept,
  output logic                 o_illegal,
  output logic                 o_fu_start,
  output logic                 o_rd_en,
  output logic [ELEM_W-1:0]    o_rd_elem,
  output logic                 o_wr_en,
  output logic [2:0]           o_wr_reg,
  output logic [ELEM_W-1:0]    o_wr_elem,
  output logic                 o_vm_wr,
  output logic [NUM_VREGS-1:0] o_vreg_busy
);

  localparam logic [ELEM_W-1:0] DRAIN_LAST = ELEM_W'(LATENCY - 1);

  state_t               state_q, state_d;
  logic [ELEM_W-1:0]    cnt_q, cnt_d;
  logic [ELEM_W-1:0]    last_elem_q, vl_last;
  logic                 accept_q, illegal_q, mask_q;
  logic [2:0]           wr_reg_q;
  logic [NUM_VREGS-1:0] busy_q;

  use_t                 req_use;
  logic [NUM_VREGS-1:0] req_mask;
  logic                 req_legal, accept, illegal_req;

  logic                 dly_valid, dly_last;
  logic [ELEM_W-1:0]    dly_elem;

  assign req_legal   = is_legal(i_instr);
  assign req_use     = decode_use(i_instr, i_i, i_j, i_k);
  assign req_mask    = use_mask(req_use, i_i, i_j, i_k);
  assign accept      = i_issue && (state_q == IDLE) && req_legal &&
                       ((req_mask & i_vreg_busy_ext) == '0);
  assign illegal_req = i_issue && (state_q == IDLE) && !req_legal;

  // A length of 0 or anything beyond the register size means a full register.
  always_comb begin
    if (i_vl == '0 || 32'(i_vl) > 32'(MAX_VL)) vl_last = ELEM_W'(MAX_VL - 1);
    else                                       vl_last = ELEM_W'(32'(i_vl) - 1);
  end

  // NOTE: next-state logic assigns every output a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (cnt_q == last_elem_q) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_elem_q <= '0;
      accept_q    <= 1'b0;
      illegal_q   <= 1'b0;
      mask_q      <= 1'b0;
      wr_reg_q    <= '0;
      busy_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      accept_q  <= accept;
      illegal_q <= illegal_req;
      if (accept) begin
        last_elem_q <= vl_last;
        mask_q      <= req_use.writes_vm;
        wr_reg_q    <= i_i;
        busy_q      <= req_mask;
      end else if (state_q == DRAIN && state_d == IDLE) begin
        busy_q <= '0;
      end
    end
  end

  vl_write_delay #(.LATENCY(LATENCY)) u_write_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (o_rd_en),
    .in_elem   (cnt_q),
    .in_last   (cnt_q == last_elem_q),
    .out_valid (dly_valid),
    .out_elem  (dly_elem),
    .out_last  (dly_last)
  );

  assign o_ready     = (state_q == IDLE);
  assign o_accept    = accept_q;
  assign o_fu_start  = accept_q;
  assign o_illegal   = illegal_q;
  assign o_rd_en     = (state_q == READ);
  assign o_rd_elem   = o_rd_en ? cnt_q : '0;
  assign o_wr_en     = dly_valid && !mask_q;
  assign o_wr_elem   = o_wr_en ? dly_elem : '0;
  assign o_wr_reg    = wr_reg_q;
  assign o_vm_wr     = dly_valid && dly_last && mask_q;
  assign o_vreg_busy = busy_q;

endmodule

// File: tb/tb_vector_logical_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized instructions against a cycle-by-cycle behavioural model.
module tb_vector_logical_sequencer;

  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_issue;
  logic [6:0] i_instr;
  logic [2:0] i_i, i_j, i_k;
  logic [6:0] i_vl;
  logic [7:0] i_vreg_busy_ext;
  logic       o_ready, o_accept, o_illegal, o_fu_start, o_rd_en, o_wr_en, o_vm_wr;
  logic [5:0] o_rd_elem, o_wr_elem;
  logic [2:0] o_wr_reg;
  logic [7:0] o_vreg_busy;

  int checks = 0;
  int errors = 0;

  vector_logical_sequencer #(.LATENCY(L), .VL_W(7)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_issue         (i_issue),
    .i_instr         (i_instr),
    .i_i             (i_i),
    .i_j             (i_j),
    .i_k             (i_k),
    .i_vl            (i_vl),
    .i_vreg_busy_ext (i_vreg_busy_ext),
    .o_ready         (o_ready),
    .o_accept        (o_accept),
    .o_illegal       (o_illegal),
    .o_fu_start      (o_fu_start),
    .o_rd_en         (o_rd_en),
    .o_rd_elem       (o_rd_elem),
    .o_wr_en         (o_wr_en),
    .o_wr_reg        (o_wr_reg),
    .o_wr_elem       (o_wr_elem),
    .o_vm_wr         (o_vm_wr),
    .o_vreg_busy     (o_vreg_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] instr;
    logic [2:0] i, j, k;
    logic [6:0] vl;
    logic [7:0] ext;
    int         n;
    logic [7:0] busy;
    bit         mask;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: effective length and register footprint from the opcode rules.
  function automatic int model_n(input logic [6:0] vl);
    return (vl == 0 || vl > 64) ? 64 : int'(vl);
  endfunction

  function automatic logic [7:0] model_busy(input logic [6:0] instr, input logic [2:0] i,
                                            input logic [2:0] j, input logic [2:0] k);
    logic [7:0] b;
    if (instr == 7'b1111101)                          b = 8'(1 << j);
    else if (instr == 7'b1100101 && i == j && j == k) b = 8'(1 << i);
    else if (instr[0] == 1'b0)                        b = 8'(1 << i) | 8'(1 << k);
    else                                              b = 8'(1 << i) | 8'(1 << j) | 8'(1 << k);
    return b;
  endfunction

  // Starts at a negedge with the DUT idle; ends at the negedge of the cycle
  // where o_ready returns, so consecutive calls issue back-to-back.
  task automatic run_instr(input logic [6:0] instr, input logic [2:0] i, input logic [2:0] j,
                           input logic [2:0] k, input logic [6:0] vl, input logic [7:0] ext,
                           input int n, input logic [7:0] busy, input bit mask,
                           input string tag);
    bit exp_wr;
    check({tag, " ready_before"}, o_ready, 1);
    i_issue = 1'b1; i_instr = instr; i_i = i; i_j = j; i_k = k; i_vl = vl;
    i_vreg_busy_ext = ext;
    for (int c = 1; c <= n + L + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        i_issue = 1'b0;
        i_vreg_busy_ext = '0;
        check({tag, " illegal"}, o_illegal, 0);
      end
      check($sformatf("%s c%0d accept", tag, c), o_accept, (c == 1));
      check($sformatf("%s c%0d fu_start", tag, c), o_fu_start, (c == 1));
      check($sformatf("%s c%0d rd_en", tag, c), o_rd_en, (c <= n));
      if (c <= n) check($sformatf("%s c%0d rd_elem", tag, c), o_rd_elem, c - 1);
      exp_wr = !mask && c >= L + 1 && c <= n + L;
      check($sformatf("%s c%0d wr_en", tag, c), o_wr_en, exp_wr);
      if (exp_wr) begin
        check($sformatf("%s c%0d wr_elem", tag, c), o_wr_elem, c - 1 - L);
        check($sformatf("%s c%0d wr_reg", tag, c), o_wr_reg, i);
      end
      check($sformatf("%s c%0d vm_wr", tag, c), o_vm_wr, (mask && c == n + L));
      check($sformatf("%s c%0d busy", tag, c), o_vreg_busy, (c <= n + L) ? busy : 8'h00);
      check($sformatf("%s c%0d ready", tag, c), o_ready, (c == n + L + 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready"}, o_ready, 1);
    check({tag, " accept"}, o_accept, 0);
    check({tag, " illegal"}, o_illegal, 0);
    check({tag, " fu_start"}, o_fu_start, 0);
    check({tag, " rd_en"}, o_rd_en, 0);
    check({tag, " wr_en"}, o_wr_en, 0);
    check({tag, " vm_wr"}, o_vm_wr, 0);
    check({tag, " busy"}, o_vreg_busy, 0);
  endtask

  initial begin
    logic [6:0] ops[9];
    logic [6:0] op, vl;
    logic [2:0] ri, rj, rk;
    logic [7:0] b, ext;

    ops = '{7'b1100000, 7'b1100001, 7'b1100010, 7'b1100011, 7'b1100100,
            7'b1100101, 7'b1100110, 7'b1100111, 7'b1111101};

    // instr, i, j, k, vl, ext, expected n, expected busy, mask
    tbl[0] = '{7'b1100001, 3'd2, 3'd3, 3'd4, 7'd5,   8'h01, 5,  8'h1C, 1'b0}; // VEC_AND
    tbl[1] = '{7'b1100001, 3'd2, 3'd3, 3'd4, 7'd0,   8'h00, 64, 8'h1C, 1'b0}; // vl=0
    tbl[2] = '{7'b1100100, 3'd0, 3'd7, 3'd1, 7'd100, 8'h80, 64, 8'h03, 1'b0}; // SCAL_XOR vl=100
    tbl[3] = '{7'b1111101, 3'd0, 3'd1, 3'd0, 7'd3,   8'h01, 3,  8'h02, 1'b1}; // mask
    tbl[4] = '{7'b1100101, 3'd5, 3'd5, 3'd5, 7'd1,   8'h00, 1,  8'h20, 1'b0}; // clear
    tbl[5] = '{7'b1100111, 3'd7, 3'd6, 3'd0, 7'd64,  8'h00, 64, 8'hC1, 1'b0}; // VEC_MRG
    tbl[6] = '{7'b1100000, 3'd3, 3'd3, 3'd3, 7'd2,   8'h00, 2,  8'h08, 1'b0}; // SCAL_AND
    tbl[7] = '{7'b1100101, 3'd4, 3'd4, 3'd5, 7'd65,  8'h00, 64, 8'h30, 1'b0}; // VEC_XOR

    rst = 1'b1; i_issue = 1'b0; i_instr = '0; i_i = '0; i_j = '0; i_k = '0;
    i_vl = '0; i_vreg_busy_ext = '0;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    for (int t = 0; t < 8; t++)
      run_instr(tbl[t].instr, tbl[t].i, tbl[t].j, tbl[t].k, tbl[t].vl, tbl[t].ext,
                tbl[t].n, tbl[t].busy, tbl[t].mask, $sformatf("tbl%0d", t));

    // SCAL_OR blocked by a reservation on Vk, then taken with only Vj reserved.
    i_issue = 1'b1; i_instr = 7'b1100010; i_i = 3'd1; i_j = 3'd5; i_k = 3'd6; i_vl = 7'd4;
    i_vreg_busy_ext = 8'h40;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("blocked c%0d accept", c), o_accept, 0);
      check($sformatf("blocked c%0d ready", c), o_ready, 1);
      check($sformatf("blocked c%0d rd_en", c), o_rd_en, 0);
    end
    run_instr(7'b1100010, 3'd1, 3'd5, 3'd6, 7'd4, 8'h20, 4, 8'h42, 1'b0, "unblocked");

    // Unsupported opcode: single illegal pulse, nothing else moves.
    i_issue = 1'b1; i_instr = 7'b1110000; i_i = 3'd1; i_j = 3'd2; i_k = 3'd3; i_vl = 7'd4;
    @(negedge clk);
    i_issue = 1'b0;
    check("illegal pulse", o_illegal, 1);
    check("illegal accept", o_accept, 0);
    check("illegal rd_en", o_rd_en, 0);
    check("illegal ready", o_ready, 1);
    check("illegal busy", o_vreg_busy, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("illegal_after c%0d", c), {o_illegal, o_rd_en, o_wr_en, o_vm_wr}, 4'b0000);
      check($sformatf("illegal_after c%0d ready", c), o_ready, 1);
    end

    // Reset in cycle 4 of a vl=10 VEC_OR.
    i_issue = 1'b1; i_instr = 7'b1100011; i_i = 3'd0; i_j = 3'd1; i_k = 3'd2; i_vl = 7'd10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) i_issue = 1'b0;
      check($sformatf("pre_rst c%0d rd_en", c), o_rd_en, 1);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check($sformatf("after_rst c%0d wr/vm/rd", c), {o_wr_en, o_vm_wr, o_rd_en}, 3'b000);
    end
    run_instr(7'b1100001, 3'd6, 3'd7, 3'd0, 7'd3, 8'h00, 3, 8'hC1, 1'b0, "after_rst_issue");

    // Randomized instructions against the model, issued back-to-back.
    for (int r = 0; r < 24; r++) begin
      op = ops[$urandom_range(0, 8)];
      ri = 3'($urandom_range(0, 7));
      rj = 3'($urandom_range(0, 7));
      rk = 3'($urandom_range(0, 7));
      if (op == 7'b1100101 && $urandom_range(0, 2) == 0) begin
        rj = ri;
        rk = ri;
      end
      vl  = 7'($urandom_range(0, 127));
      b   = model_busy(op, ri, rj, rk);
      ext = 8'($urandom) & ~b;
      run_instr(op, ri, rj, rk, vl, ext, model_n(vl), b, (op == 7'b1111101),
                $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
